imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the decode-side immediate sign extension: takes a 32-bit immediate plus a base instruction word
//  and inserts the immediate into the I/S/B (optionally U) bit fields. Range- and alignment-checks the
//  immediate, counts rejected immediates. 2-stage valid/ready pipeline.
//  Sits in the program-loader / self-test path feeding instruction memory.
// PARAMETERS
//  DATA_WIDTH  32  immediate and instruction width (only 32 supported)
//  CNT_WIDTH   8   width of saturating error counter
// PORTS
//  clk       in   1           clock; all state updates on rising edge
//  rst       in   1           synchronous, active-high reset
//  in_valid  in   1           input beat valid
//  in_ready  out  1           block can accept input beat
//  ImmSrc    in   2           00 I-type, 01 S-type, 10 B-type, 11 U-type (see CONFIGURATION)
//  Imm       in   DATA_WIDTH  immediate value (two's complement)
//  Base      in   DATA_WIDTH  instruction with opcode/rd/rs1/rs2/funct set; imm field bits ignored
//  out_valid out  1           output beat valid
//  out_ready in   1           downstream accepts output beat
//  Instr     out  DATA_WIDTH  encoded instruction
//  RangeErr  out  1           Imm not representable in selected format (or ImmSrc illegal)
//  AlignErr  out  1           B-type with Imm[0]=1
//  ErrCount  out  CNT_WIDTH   count of output beats accepted with RangeErr|AlignErr; saturates at all-ones
// BEHAVIOUR
//  - Reset: out_valid=0, Instr=0, RangeErr=0, AlignErr=0, ErrCount=0, both stage valids cleared; in_ready=1
//    in the cycle after reset. Reset mid-operation discards in-flight beats; no output is produced for them.
//  - Handshake: transfer when valid&&ready. Stage k advances when stage k+1 is empty or transferring.
//    in_ready = !s1_valid || s1_adv (combinational from out_ready through stage chain; no skid).
//  - While out_valid && !out_ready: Instr, RangeErr, AlignErr held stable.
//  - Latency: 2 cycles input-accept to out_valid; throughput 1 beat/cycle with out_ready held high.
//  - Stage 1 registers ImmSrc/Imm/Base and computes flags; stage 2 registers packed Instr and flags.
//  - Packing (bits not listed come from Base):
//    I: Instr[31:20]=Imm[11:0]
//    S: Instr[31:25]=Imm[11:5], Instr[11:7]=Imm[4:0]
//    B: Instr[31]=Imm[12], Instr[30:25]=Imm[10:5], Instr[11:8]=Imm[4:1], Instr[7]=Imm[11]; Imm[0] dropped
//  - Range: I/S require Imm[31:11] all equal; B requires Imm[31:12] all equal.
//    B alignment: AlignErr=Imm[0].
//  - On error the truncated packing is still output; flags only report.
//  - ErrCount increments on output transfer with any flag set; holds at 2**CNT_WIDTH-1.
// CONFIGURATION
//  Macro IMM_U_TYPE_EN:
//    defined: ImmSrc=11 is U-type: Instr[31:12]=Imm[31:12], Instr[11:0]=Base[11:0];
//             RangeErr=|Imm[11:0].
//    undefined: ImmSrc=11 illegal: Instr=Base unchanged, RangeErr=1, AlignErr=0.
// STRUCTURE
//  - Package imm_pkg: localparams IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_U=2'b11;
//    DATA_WIDTH default constant.
//  - Sub-module imm_pack (combinational: ImmSrc, Imm, Base -> Instr, RangeErr, AlignErr), instantiated
//    between stage 1 and stage 2 registers.
// TESTING
//  - I: ImmSrc=00, Imm=0xFFFFF800 (-2048), Base=0x00000013 -> Instr=0x80000013, no flags, 2 cycles later.
//  - S: ImmSrc=01, Imm=0x0000007F, Base=0x00002023 -> Instr=0x06002FA3, no flags; then Imm=0x800 ->
//    RangeErr=1, ErrCount=1.
//  - B: ImmSrc=10, Imm=0xFFFFFFFC (-4), Base=0x00000063 -> Instr=0xFE000EE3; Imm=0x3 -> AlignErr=1.
//  - Backpressure: stream 4 beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted,
//    Instr/flags stable, all 4 delivered in order, none duplicated.
//  - Reset mid-stream with 2 beats in flight -> out_valid=0 next cycle, ErrCount=0, no stale beat emitted;
//    also 256 error beats -> ErrCount stays 0xFF.
//  - Round-trip: random Imm in range per format -> decode-side sign extension of Instr equals Imm
//    (B: Imm with bit0=0). U: IMM_U_TYPE_EN off -> RangeErr=1, Instr=Base.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants and helpers for the immediate encoder (format selects, default width, range test).
package imm_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  // True when v[31:msb] are all equal, i.e. v fits a signed field whose sign bit sits at msb.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] sh;
    sh = $signed(v) >>> msb;
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Upstream/downstream valid-ready bus of the immediate encoder; slave is the encoder's view.
interface imm_encoder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            ImmSrc;
  logic [DATA_WIDTH-1:0] Imm;
  logic [DATA_WIDTH-1:0] Base;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Instr;
  logic                  RangeErr;
  logic                  AlignErr;
  logic [CNT_WIDTH-1:0]  ErrCount;

  modport slave (
    input  in_valid, ImmSrc, Imm, Base, out_ready,
    output in_ready, out_valid, Instr, RangeErr, AlignErr, ErrCount
  );

  modport master (
    output in_valid, ImmSrc, Imm, Base, out_ready,
    input  in_ready, out_valid, Instr, RangeErr, AlignErr, ErrCount
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational immediate packer: merges Imm into the I/S/B(/U) fields of Base and flags bad immediates.
// U-type packing exists only when IMM_U_TYPE_EN is defined; otherwise ImmSrc=11 is rejected.
module imm_pack
  import imm_pkg::*;
(
  input  logic [1:0]                    ImmSrc,
  input  logic [DEFAULT_DATA_WIDTH-1:0] Imm,
  input  logic [DEFAULT_DATA_WIDTH-1:0] Base,
  output logic [DEFAULT_DATA_WIDTH-1:0] Instr,
  output logic                          RangeErr,
  output logic                          AlignErr
);

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    Instr    = Base;
    RangeErr = 1'b0;
    AlignErr = 1'b0;
    case (ImmSrc)
      IMM_I: begin
        Instr[31:20] = Imm[11:0];
        RangeErr     = !fits_signed(Imm, 11);
      end
      IMM_S: begin
        Instr[31:25] = Imm[11:5];
        Instr[11:7]  = Imm[4:0];
        RangeErr     = !fits_signed(Imm, 11);
      end
      IMM_B: begin
        // Imm[0] has no slot; a set bit is reported as misalignment instead.
        Instr[31]    = Imm[12];
        Instr[30:25] = Imm[10:5];
        Instr[11:8]  = Imm[4:1];
        Instr[7]     = Imm[11];
        RangeErr     = !fits_signed(Imm, 12);
        AlignErr     = Imm[0];
      end
      default: begin
`ifdef IMM_U_TYPE_EN
        Instr[31:12] = Imm[31:12];
        RangeErr     = |Imm[11:0];
`else
        RangeErr     = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with a saturating count of rejected output beats.
// Optional macro IMM_U_TYPE_EN enables U-type packing for ImmSrc=11 (see imm_pack).
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  logic                  s1_valid;
  logic [1:0]            s1_src;
  logic [DATA_WIDTH-1:0] s1_imm;
  logic [DATA_WIDTH-1:0] s1_base;

  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_instr;
  logic                  s2_range;
  logic                  s2_align;
  logic [CNT_WIDTH-1:0]  err_cnt;

  logic [DATA_WIDTH-1:0] p_instr;
  logic                  p_range;
  logic                  p_align;
  logic                  in_fire;
  logic                  s1_adv;
  logic                  out_fire;

  // Ready ripples back combinationally from out_ready; there is no skid buffer.
  assign out_fire     = s2_valid && bus.out_ready;
  assign s1_adv       = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)          s1_valid <= 1'b0;
    else if (in_fire) s1_valid <= 1'b1;
    else if (s1_adv)  s1_valid <= 1'b0;
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_src  <= bus.ImmSrc;
      s1_imm  <= bus.Imm;
      s1_base <= bus.Base;
    end
  end

  imm_pack u_pack (
    .ImmSrc   (s1_src),
    .Imm      (s1_imm),
    .Base     (s1_base),
    .Instr    (p_instr),
    .RangeErr (p_range),
    .AlignErr (p_align)
  );

  // Output payload is loaded only on advance, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_range <= 1'b0;
      s2_align <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_instr <= p_instr;
      s2_range <= p_range;
      s2_align <= p_align;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (out_fire && (s2_range || s2_align) && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end

  assign bus.out_valid = s2_valid;
  assign bus.Instr     = s2_instr;
  assign bus.RangeErr  = s2_range;
  assign bus.AlignErr  = s2_align;
  assign bus.ErrCount  = err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: the driver queues expected beats, the monitor pops and compares.
module tb_imm_encoder;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_encoder_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

  imm_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rt;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        range_err;
    logic        align_err;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   beat_id  = 0;
  int   accepted = 0;

  logic        hold_pending = 1'b0;
  logic [31:0] held_instr;
  logic [31:0] held_flags;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (beat %0d): got 0x%08h expected 0x%08h", name, id, act, exp);
    end
  endtask

  // Decode-side sign extension, the inverse of the encoder.
  function automatic logic [31:0] decode_imm(input logic [1:0] src, input logic [31:0] ins);
    case (src)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      default: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [1:0] src);
    return (src == IMM_I) ? 32'h000F_FFFF : 32'h01FF_F07F;
  endfunction

  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] instr, input logic rerr, input logic aerr, input bit rt);
    exp_t e;
    bit   done = 1'b0;
    bus.in_valid = 1'b1;
    bus.ImmSrc   = src;
    bus.Imm      = imm;
    bus.Base     = base;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        e.rt = rt; e.src = src; e.imm = imm; e.base = base; e.instr = instr;
        e.range_err = rerr; e.align_err = aerr; e.id = beat_id;
        sb.push_back(e);
        beat_id++;
        accepted++;
        done = 1'b1;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (!done) check("accept_timeout", beat_id, 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      check("drain_timeout", sb.size(), 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // Monitor: pops on every output transfer and checks stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && bus.out_valid) begin
        check("hold_instr", -1, bus.Instr, held_instr);
        check("hold_flags", -1, {30'd0, bus.RangeErr, bus.AlignErr}, held_flags);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got Instr 0x%08h expected no beat", bus.Instr);
        end else begin
          e = sb.pop_front();
          if (e.rt) begin
            check("rt_imm", e.id, decode_imm(e.src, bus.Instr), e.imm);
            check("rt_base", e.id, bus.Instr & field_mask(e.src), e.base & field_mask(e.src));
          end else begin
            check("instr", e.id, bus.Instr, e.instr);
          end
          check("range_err", e.id, {31'd0, bus.RangeErr}, {31'd0, e.range_err});
          check("align_err", e.id, {31'd0, bus.AlignErr}, {31'd0, e.align_err});
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held_instr   = bus.Instr;
      held_flags   = {30'd0, bus.RangeErr, bus.AlignErr};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] imm;
    logic [1:0]  src;
    int          exp_err;

    bus.in_valid  = 1'b0;
    bus.ImmSrc    = 2'b00;
    bus.Imm       = '0;
    bus.Base      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", -1, {31'd0, bus.out_valid}, 32'd0);
    check("rst_instr",     -1, bus.Instr, 32'd0);
    check("rst_flags",     -1, {30'd0, bus.RangeErr, bus.AlignErr}, 32'd0);
    check("rst_errcount",  -1, {24'd0, bus.ErrCount}, 32'd0);
    check("rst_in_ready",  -1, {31'd0, bus.in_ready}, 32'd1);

    // Directed vectors.
    send(IMM_I, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b0, 1'b0);
    send(IMM_S, 32'h0000_007F, 32'h0000_2023, 32'h0600_2FA3, 1'b0, 1'b0, 1'b0);
    send(IMM_S, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0, 1'b0);
    drain();
    check("errcount_after_s", -1, {24'd0, bus.ErrCount}, 32'd1);
    send(IMM_B, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 1'b0, 1'b0);
    send(IMM_B, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b0, 1'b1, 1'b0);
`ifdef IMM_U_TYPE_EN
    send(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b0, 1'b0);
    exp_err = 2;
`else
    send(IMM_U, 32'h1234_5000, 32'h0000_0037, 32'h0000_0037, 1'b1, 1'b0, 1'b0);
    exp_err = 3;
`endif
    drain();
    check("errcount_directed", -1, {24'd0, bus.ErrCount}, exp_err);

    // Backpressure: four beats against a stalled output.
    bus.out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(IMM_I, 32'h0000_0001, 32'h0000_0013, 32'h0010_0013, 1'b0, 1'b0, 1'b0);
        send(IMM_I, 32'h0000_0002, 32'h0000_0013, 32'h0020_0013, 1'b0, 1'b0, 1'b0);
        send(IMM_I, 32'h0000_0003, 32'h0000_0013, 32'h0030_0013, 1'b0, 1'b0, 1'b0);
        send(IMM_I, 32'h0000_0004, 32'h0000_0013, 32'h0040_0013, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_in_ready", -1, {31'd0, bus.in_ready}, 32'd0);
        check("bp_accepted", -1, accepted, 32'd2);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Round trip through decode-side sign extension.
    for (int k = 0; k < 6; k++) begin
      src = 2'(k % 3);
      r   = $urandom;
      if (src == IMM_B) imm = {{19{r[12]}}, r[12:1], 1'b0};
      else              imm = {{20{r[11]}}, r[11:0]};
      send(src, imm, $urandom, 32'd0, 1'b0, 1'b0, 1'b1);
    end
    drain();

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(IMM_S, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0, 1'b0);
    send(IMM_S, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_out_valid", -1, {31'd0, bus.out_valid}, 32'd0);
    check("midrst_errcount",  -1, {24'd0, bus.ErrCount}, 32'd0);
    check("midrst_in_ready",  -1, {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Counter saturation.
    for (int k = 0; k < 255; k++)
      send(IMM_S, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0, 1'b0);
    drain();
    check("errcount_255", -1, {24'd0, bus.ErrCount}, 32'h0000_00FF);
    send(IMM_S, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0, 1'b0);
    drain();
    check("errcount_sat", -1, {24'd0, bus.ErrCount}, 32'h0000_00FF);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", -1, sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
